// File: rtl/pipe_reg_skid.sv
// Two-entry skid pipeline register: a head register that drives out_data and a skid register
// that absorbs one beat when downstream stalls, so upstream can stream at one beat per cycle.
module pipe_reg_skid #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_skid;
   logic [WIDTH-1:0] w_head_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_push;
   logic             w_pop;

   // Handshake signals are combinational from stored state and the stage controls.
   assign in_ready  = en & ~flush & (r_state != FULL);
   assign out_valid = en & ~flush & (r_state != EMPTY);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign out_data  = r_head;
   assign count     = r_state;

   // State and storage registers; active-low reset overrides everything else.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= EMPTY;
         r_head  <= RESET_VAL;
         r_skid  <= RESET_VAL;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   // Next-state and storage update; push/pop are already gated by en and flush.
   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      if (flush) begin
         w_state_nxt = EMPTY;
         w_head_nxt  = RESET_VAL;
         w_skid_nxt  = RESET_VAL;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  w_head_nxt  = in_data;
                  w_state_nxt = ONE;
               end else begin
                  w_state_nxt = EMPTY;
               end
            end
            ONE: begin
               if (w_push && w_pop) begin
                  w_head_nxt  = in_data;
                  w_state_nxt = ONE;
               end else if (w_push) begin
                  w_skid_nxt  = in_data;
                  w_state_nxt = FULL;
               end else if (w_pop) begin
                  // Head keeps the beat just delivered; it is simply no longer valid.
                  w_state_nxt = EMPTY;
               end else begin
                  w_state_nxt = ONE;
               end
            end
            FULL: begin
               if (w_pop) begin
                  w_head_nxt  = r_skid;
                  w_state_nxt = ONE;
               end else begin
                  w_state_nxt = FULL;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
               w_head_nxt  = RESET_VAL;
               w_skid_nxt  = RESET_VAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_reg_skid.sv
// Self-checking bench for pipe_reg_skid: directed scenarios plus random traffic, all checked
// against a queue-based model of the stage's stored beats.
module tb_pipe_reg_skid;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;

   logic         clk = 1'b0;
   logic         reset, en, flush, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid;
   logic [W-1:0] out_data;
   logic [1:0]   count;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] m_q[$];
   logic [W-1:0] m_last;

   pipe_reg_skid #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs against the model, clock, update the model.
   task automatic step(input logic s_rst, input logic s_en, input logic s_fl,
                       input logic s_iv, input logic [W-1:0] s_d, input logic s_or);
      logic         e_ir, e_ov, e_push, e_pop;
      logic [W-1:0] e_dat;
      reset = s_rst; en = s_en; flush = s_fl;
      in_valid = s_iv; in_data = s_d; out_ready = s_or;
      #1;
      e_ir  = s_en && !s_fl && (m_q.size() < 2);
      e_ov  = s_en && !s_fl && (m_q.size() > 0);
      e_dat = (m_q.size() > 0) ? m_q[0] : m_last;
      chk("count",     {30'd0, count},      m_q.size());
      chk("in_ready",  {31'd0, in_ready},   {31'd0, e_ir});
      chk("out_valid", {31'd0, out_valid},  {31'd0, e_ov});
      chk("out_data",  {24'd0, out_data},   {24'd0, e_dat});
      e_push = s_iv && e_ir;
      e_pop  = e_ov && s_or;
      @(posedge clk);
      if (!s_rst || s_fl) begin
         m_q.delete();
         m_last = RV;
      end else begin
         if (e_pop) m_last = m_q.pop_front();
         if (e_push) m_q.push_back(s_d);
      end
      #1;
   endtask

   initial begin
      reset = 1'b0; en = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
      m_last = RV;
      @(posedge clk); #1;

      // Post-reset state, and reset held with en=1 gives in_ready = en & ~flush.
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

      // Streaming 01..08 with downstream always ready.
      for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 1'b1, i[7:0], 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Backpressure: 11, 22 stored, 33 held upstream, then drained in order.
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Full stage stalled by en=0, then resumed.
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 8'h66, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Flush while full with en=0 and an incoming beat.
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'h88, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Reset with one beat stored and handshakes active.
      step(1'b1, 1'b1, 1'b0, 1'b1, 8'hAB, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b1, 8'hCD, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) != 0), ($urandom_range(0, 7) != 0),
              ($urandom_range(0, 29) == 0), $urandom_range(0, 1) == 1,
              8'($urandom), $urandom_range(0, 3) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_reg_skid.md
PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

Interface
REQ-001 Parameter WIDTH, default 8: bit width of in_data, out_data and both storage registers.
REQ-002 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into both storage registers on reset or flush.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous active-low reset, sampled on the rising edge of clk.
REQ-005 Port en  input  1: stage enable; 0 stalls both handshake sides.
REQ-006 Port flush  input  1: synchronous clear of all stored beats; takes priority over en.
REQ-007 Port in_valid  input  1: upstream beat present.
REQ-008 Port in_ready  output  1: stage can accept a beat this cycle.
REQ-009 Port in_data  input  WIDTH: upstream payload.
REQ-010 Port out_valid  output  1: head beat presented downstream.
REQ-011 Port out_ready  input  1: downstream accepts head beat.
REQ-012 Port out_data  output  WIDTH: head beat payload.
REQ-013 Port count  output  2: stored beats, 0..2.

Function
REQ-014 Storage SHALL be two WIDTH-bit registers: head (drives out_data) and skid; count SHALL encode states EMPTY=0, ONE=1, FULL=2; value 3 is unreachable.
REQ-015 in_ready SHALL equal en & ~flush & (count != 2), combinational from state and inputs.
REQ-016 out_valid SHALL equal en & ~flush & (count != 0).
REQ-017 Push SHALL occur when in_valid & in_ready; pop SHALL occur when out_valid & out_ready.
REQ-018 EMPTY + push: head <= in_data, count -> 1; out_valid high the next cycle (one-cycle latency).
REQ-019 ONE + push, no pop: skid <= in_data, count -> 2.
REQ-020 ONE + pop, no push: count -> 0; head retains its last value.
REQ-021 ONE + push + pop: head <= in_data, count stays 1 (full throughput, one beat per cycle).
REQ-022 FULL + pop: head <= skid, count -> 1; push is impossible (in_ready = 0).
REQ-023 Beats SHALL leave in strict arrival order; no beat duplicated or dropped except by flush or reset.
REQ-024 en = 0 without flush: no push, no pop, all registers hold.
REQ-025 flush = 1 (any en): count -> 0, head and skid <= RESET_VAL next edge; no beat accepted or delivered in the flush cycle.
REQ-026 out_data SHALL equal head in every cycle; it is meaningful only while out_valid = 1.

Reset
REQ-027 reset = 0 at a rising edge SHALL set count = 0 and head = skid = RESET_VAL, overriding flush, en and handshakes.
REQ-028 While reset = 0, in_ready and out_valid SHALL be driven by the post-reset state only after the edge; the bench SHALL check in_ready = en & ~flush and out_valid = 0 the cycle after reset.
REQ-029 Reset mid-operation SHALL discard stored beats; no beat accepted in the reset cycle is delivered.

Verification
REQ-030 Reset, en=1, RESET_VAL=8'hA5 -> count=0, out_valid=0, out_data=8'hA5, in_ready=1.
REQ-031 Stream 8'h01..8'h08 with out_ready=1 constantly -> out_data 01..08 on consecutive cycles, first one cycle after first push, count stays 1.
REQ-032 Push 8'h11, 8'h22 with out_ready=0 -> count=2, in_ready=0, 8'h33 held upstream; then out_ready=1 -> 11, 22, 33 delivered in order.
REQ-033 count=2, en=0 for 3 cycles with in_valid=out_ready=1 -> in_ready=out_valid=0, count=2, contents unchanged; en=1 -> drain resumes in order.
REQ-034 count=2, flush=1 with en=0 and in_valid=1 -> next cycle count=0, out_data=RESET_VAL, incoming beat not stored.
REQ-035 count=1, reset=0 asserted with in_valid=out_ready=1 -> count=0, out_valid=0, no beat delivered in the following cycle.
